// File: rtl/glyph_serializer_if.sv
// glyph_serializer_if: character, glyph-ROM and pixel-stream signals of the glyph serializer
//   master: serializer side (accepts characters, drives glyph requests and the pixel stream)
//   slave : environment side (character source, glyph stage, framebuffer writer)
interface glyph_serializer_if #(
  parameter int WIDTH = 8,
  parameter int HEIGHT = 16,
  parameter int UCPW = 21,
  parameter int COLRW = 4
);
  logic ch_valid;
  logic ch_ready;
  logic [UCPW-1:0] ch_ucp;
  logic [COLRW-1:0] ch_fg;
  logic [COLRW-1:0] ch_bg;
  logic [UCPW-1:0] glyph_ucp;
  logic [$clog2(HEIGHT)-1:0] glyph_line;
  logic [WIDTH-1:0] glyph_pix;
  logic pix_valid;
  logic pix_ready;
  logic [COLRW-1:0] pix_colour;
  logic [$clog2(WIDTH)-1:0] pix_x;
  logic [$clog2(HEIGHT)-1:0] pix_y;
  logic pix_last;
  modport master (
    input ch_valid, ch_ucp, ch_fg, ch_bg, glyph_pix, pix_ready,
    output ch_ready, glyph_ucp, glyph_line, pix_valid, pix_colour, pix_x, pix_y, pix_last
  );
  modport slave (
    output ch_valid, ch_ucp, ch_fg, ch_bg, glyph_pix, pix_ready,
    input ch_ready, glyph_ucp, glyph_line, pix_valid, pix_colour, pix_x, pix_y, pix_last
  );
endinterface

// File: rtl/glyph_serializer.sv
// glyph_serializer: turns one character into a row-major coloured pixel stream via the glyph ROM stage
//   clk, rst : clock, synchronous active-low reset
//   bus      : ch_* character handshake in, glyph_ucp/glyph_line request out, glyph_pix line in,
//              pix_* pixel handshake out (colour, x, y, last)
//   GLYPH_SER_PREFETCH_EN : fetch line n+1 into a shadow register while line n streams out
module glyph_serializer #(
  parameter int WIDTH = 8,
  parameter int HEIGHT = 16,
  parameter int UCPW = 21,
  parameter int COLRW = 4,
  parameter int GLYPH_LAT = 4
) (
  input logic clk,
  input logic rst,
  glyph_serializer_if.master bus
);
  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam int CW = $clog2(GLYPH_LAT + 1);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, SHIFT} state_t;
  state_t state, state_n;
  logic [WIDTH-1:0] shift_q;
  logic [XW-1:0] col;
  logic [YW-1:0] line, gline;
  logic [UCPW-1:0] gucp;
  logic [COLRW-1:0] fg, bg;
  logic [CW-1:0] wcnt;
  logic hs, end_row, end_glyph, wait_done, next_rdy;
`ifdef GLYPH_SER_PREFETCH_EN
  logic [WIDTH-1:0] shadow, next_pix;
  logic shadow_v, pf_pend, pf_cap, enter_shift;
  logic [CW-1:0] pf_cnt;
  logic [YW-1:0] new_line;
  // a row ending before its prefetch returned waits for that same request
  localparam state_t MISS = WAIT;
`else
  localparam state_t MISS = REQ;
`endif
  assign bus.ch_ready = rst && state == IDLE;
  assign bus.glyph_ucp = gucp;
  assign bus.glyph_line = gline;
  assign bus.pix_valid = state == SHIFT;
  assign bus.pix_x = col;
  assign bus.pix_y = line;
  assign bus.pix_colour = state != SHIFT ? '0 : shift_q[col] ? fg : bg;
  assign bus.pix_last = state == SHIFT && col == XW'(WIDTH - 1) && line == YW'(HEIGHT - 1);
  always_comb begin
    hs = state == SHIFT && bus.pix_ready;
    end_row = hs && col == XW'(WIDTH - 1);
    end_glyph = end_row && line == YW'(HEIGHT - 1);
`ifdef GLYPH_SER_PREFETCH_EN
    pf_cap = pf_pend && pf_cnt == '0;
    wait_done = pf_pend ? pf_cap : wcnt == '0;
    // a capture landing on the last-column handshake is used directly
    next_rdy = shadow_v || pf_cap;
    next_pix = shadow_v ? shadow : bus.glyph_pix;
    enter_shift = (state == WAIT && wait_done) || (end_row && !end_glyph && next_rdy);
    new_line = state == WAIT ? line : line + 1'b1;
`else
    wait_done = wcnt == '0;
    next_rdy = 1'b0;
`endif
    state_n = state == IDLE ? (bus.ch_valid ? REQ : IDLE) :
              state == REQ ? WAIT :
              state == WAIT ? (wait_done ? SHIFT : WAIT) :
              !end_row ? SHIFT : end_glyph ? IDLE : next_rdy ? SHIFT : MISS;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      shift_q <= '0;
      col <= '0;
      line <= '0;
      gline <= '0;
      gucp <= '0;
      fg <= '0;
      bg <= '0;
      wcnt <= '0;
`ifdef GLYPH_SER_PREFETCH_EN
      shadow <= '0;
      shadow_v <= 1'b0;
      pf_pend <= 1'b0;
      pf_cnt <= '0;
`endif
    end else begin
      state <= state_n;
      if (state == IDLE && bus.ch_valid) begin
        fg <= bus.ch_fg;
        bg <= bus.ch_bg;
        gucp <= bus.ch_ucp;
        gline <= '0;
        line <= '0;
      end
      // REQ is cycle t; WAIT then runs t+1..t+GLYPH_LAT and captures at the end of the last one
      if (state == REQ) wcnt <= CW'(GLYPH_LAT - 1);
      if (state == WAIT && wcnt != '0) wcnt <= wcnt - 1'b1;
      if (state == WAIT && wait_done) shift_q <= bus.glyph_pix;
      if (hs) col <= end_row ? '0 : col + 1'b1;
      if (end_row && !end_glyph) line <= line + 1'b1;
`ifdef GLYPH_SER_PREFETCH_EN
      if (end_row) shadow_v <= 1'b0;
      else if (pf_cap && state == SHIFT) begin
        shadow <= bus.glyph_pix;
        shadow_v <= 1'b1;
      end
      if (end_row && !end_glyph && next_rdy) shift_q <= next_pix;
      if (pf_pend && pf_cnt != '0) pf_cnt <= pf_cnt - 1'b1;
      if (pf_cap) pf_pend <= 1'b0;
      // the first SHIFT cycle of every row but the last is the request cycle for the next row
      if (enter_shift && new_line != YW'(HEIGHT - 1)) begin
        gline <= new_line + 1'b1;
        pf_pend <= 1'b1;
        pf_cnt <= CW'(GLYPH_LAT);
      end
`else
      if (end_row && !end_glyph) gline <= line + 1'b1;
`endif
    end
  end
endmodule
